// File: rtl/vga_pkg.sv
// Shared VGA timing constants and sync-window helpers.
// Defaults describe 640x480@60 with a 25 MHz pixel clock.
// No ports: imported by vga_sync_to_count and vga_sync_porch.
package vga_pkg;

    localparam int unsigned DefVideoWidth  = 3;
    localparam int unsigned DefTotalCols   = 800;
    localparam int unsigned DefTotalRows   = 525;
    localparam int unsigned DefActiveCols  = 640;
    localparam int unsigned DefActiveRows  = 480;
    localparam int unsigned DefHFrontPorch = 16;
    localparam int unsigned DefHSyncWidth  = 96;
    localparam int unsigned DefVFrontPorch = 10;
    localparam int unsigned DefVSyncWidth  = 2;

    // First count at which the sync pulse is asserted.
    function automatic int unsigned sync_start(input int unsigned active,
                                               input int unsigned porch);
        return active + porch;
    endfunction

    // Last count (inclusive) at which the sync pulse is asserted.
    function automatic int unsigned sync_end(input int unsigned active,
                                             input int unsigned porch,
                                             input int unsigned width);
        return active + porch + width - 1;
    endfunction

    localparam int unsigned DefHSyncStart = sync_start(DefActiveCols, DefHFrontPorch);
    localparam int unsigned DefHSyncEnd   = sync_end(DefActiveCols, DefHFrontPorch,
                                                     DefHSyncWidth);
    localparam int unsigned DefVSyncStart = sync_start(DefActiveRows, DefVFrontPorch);
    localparam int unsigned DefVSyncEnd   = sync_end(DefActiveRows, DefVFrontPorch,
                                                     DefVSyncWidth);

endpackage

// File: rtl/vga_sync_to_count.sv
// Recovers column/row counts from active-area sync inputs.
// Ports:
//   clk      pixel clock
//   reset    synchronous active-high reset
//   hsync    high while the upstream column is in the active area
//   vsync    high while the upstream row is in the active area
//   hsync_q  registered hsync (alignment/debug)
//   vsync_q  registered vsync
//   col      recovered column count
//   row      recovered row count
//   locked   set once a frame start has been seen since reset
module vga_sync_to_count
    import vga_pkg::*;
#(
    parameter int unsigned TOTAL_COLS = DefTotalCols,
    parameter int unsigned TOTAL_ROWS = DefTotalRows
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          hsync,
    input  logic                          vsync,
    output logic                          hsync_q,
    output logic                          vsync_q,
    output logic [$clog2(TOTAL_COLS)-1:0] col,
    output logic [$clog2(TOTAL_ROWS)-1:0] row,
    output logic                          locked
);

    localparam int unsigned ColW = $clog2(TOTAL_COLS);
    localparam int unsigned RowW = $clog2(TOTAL_ROWS);

    localparam logic [ColW-1:0] ColLast = ColW'(TOTAL_COLS - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(TOTAL_ROWS - 1);

    logic            frame_start;
    logic [ColW-1:0] col_d;
    logic [RowW-1:0] row_d;
    logic            locked_d;

    // The sync registers keep sampling through reset so that a VSync that is
    // already high when reset releases is not mistaken for a frame start.
    always_ff @(posedge clk) begin
        hsync_q <= hsync;
        vsync_q <= vsync;
    end

    // Rising edge: input high while its registered copy is still low. Using the
    // live input keeps the count one cycle behind the pixel it describes.
    assign frame_start = vsync & ~vsync_q;

    always_comb begin
        col_d    = col + ColW'(1);
        row_d    = row;
        locked_d = locked;
        if (frame_start) begin
            col_d    = '0;
            row_d    = '0;
            locked_d = 1'b1;
        end else if (col == ColLast) begin
            col_d = '0;
            row_d = (row == RowLast) ? '0 : row + RowW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col    <= '0;
            row    <= '0;
            locked <= 1'b0;
        end else begin
            col    <= col_d;
            row    <= row_d;
            locked <= locked_d;
        end
    end

endmodule

// File: rtl/vga_sync_porch.sv
// Regenerates active-low VGA syncs with porches and blanks/aligns the video.
// Ports:
//   i_Clk                  pixel clock
//   i_Reset                synchronous active-high reset
//   i_HSync / i_VSync      active-area syncs from the game logic
//   i_Red/Grn/Blu_Video    video aligned with the input syncs
//   o_HSync / o_VSync      active-low syncs with porches
//   o_Red/Grn/Blu_Video    video aligned with the output syncs, 0 when blanked
module vga_sync_porch
    import vga_pkg::*;
#(
    parameter int unsigned VIDEO_WIDTH   = DefVideoWidth,
    parameter int unsigned TOTAL_COLS    = DefTotalCols,
    parameter int unsigned TOTAL_ROWS    = DefTotalRows,
    parameter int unsigned ACTIVE_COLS   = DefActiveCols,
    parameter int unsigned ACTIVE_ROWS   = DefActiveRows,
    parameter int unsigned H_FRONT_PORCH = DefHFrontPorch,
    parameter int unsigned H_SYNC_WIDTH  = DefHSyncWidth,
    parameter int unsigned V_FRONT_PORCH = DefVFrontPorch,
    parameter int unsigned V_SYNC_WIDTH  = DefVSyncWidth
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_HSync,
    input  logic                   i_VSync,
    input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
    output logic                   o_HSync,
    output logic                   o_VSync,
    output logic [VIDEO_WIDTH-1:0] o_Red_Video,
    output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
    output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);

    localparam int unsigned ColW = $clog2(TOTAL_COLS);
    localparam int unsigned RowW = $clog2(TOTAL_ROWS);

    localparam logic [ColW-1:0] HSyncFirst = ColW'(sync_start(ACTIVE_COLS, H_FRONT_PORCH));
    localparam logic [ColW-1:0] HSyncLast  =
        ColW'(sync_end(ACTIVE_COLS, H_FRONT_PORCH, H_SYNC_WIDTH));
    localparam logic [RowW-1:0] VSyncFirst = RowW'(sync_start(ACTIVE_ROWS, V_FRONT_PORCH));
    localparam logic [RowW-1:0] VSyncLast  =
        RowW'(sync_end(ACTIVE_ROWS, V_FRONT_PORCH, V_SYNC_WIDTH));
    localparam logic [ColW-1:0] ActiveCols = ColW'(ACTIVE_COLS);
    localparam logic [RowW-1:0] ActiveRows = RowW'(ACTIVE_ROWS);

    logic [ColW-1:0]        col;
    logic [RowW-1:0]        row;
    logic                   locked;
    logic                   hsync_q;
    logic                   vsync_q;
    logic                   unused_sync;
    logic [VIDEO_WIDTH-1:0] red_q;
    logic [VIDEO_WIDTH-1:0] grn_q;
    logic [VIDEO_WIDTH-1:0] blu_q;
    logic                   hsync_d;
    logic                   vsync_d;
    logic                   video_on;

    vga_sync_to_count #(
        .TOTAL_COLS (TOTAL_COLS),
        .TOTAL_ROWS (TOTAL_ROWS)
    ) u_count (
        .clk     (i_Clk),
        .reset   (i_Reset),
        .hsync   (i_HSync),
        .vsync   (i_VSync),
        .hsync_q (hsync_q),
        .vsync_q (vsync_q),
        .col     (col),
        .row     (row),
        .locked  (locked)
    );

    // Registered syncs are only for alignment/debug by other users of the counter.
    assign unused_sync = ^{hsync_q, vsync_q};

    always_comb begin
        hsync_d  = ~((col >= HSyncFirst) && (col <= HSyncLast));
        vsync_d  = ~((row >= VSyncFirst) && (row <= VSyncLast));
        video_on = locked && (col < ActiveCols) && (row < ActiveRows);
    end

    // First video stage lines the pixel up with the count describing it.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            red_q <= '0;
            grn_q <= '0;
            blu_q <= '0;
        end else begin
            red_q <= i_Red_Video;
            grn_q <= i_Grn_Video;
            blu_q <= i_Blu_Video;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_HSync     <= 1'b1;
            o_VSync     <= 1'b1;
            o_Red_Video <= '0;
            o_Grn_Video <= '0;
            o_Blu_Video <= '0;
        end else begin
            o_HSync     <= hsync_d;
            o_VSync     <= vsync_d;
            o_Red_Video <= video_on ? red_q : '0;
            o_Grn_Video <= video_on ? grn_q : '0;
            o_Blu_Video <= video_on ? blu_q : '0;
        end
    end

endmodule
